// File: rtl/mps16_pkg.sv
// Shared encodings for the mps16 execute stage: opcodes, R-type functs and ALU operation codes.
package mps16_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_MUL  = 6'b011000;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_NAND = 6'b101000;
   localparam logic [5:0] FN_XNOR = 6'b101010;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_ROL  = 6'b111000;
   localparam logic [5:0] FN_ROR  = 6'b110000;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_NOR  = 4'h5;
   localparam logic [3:0] ALU_NAND = 4'h6;
   localparam logic [3:0] ALU_XNOR = 4'h7;
   localparam logic [3:0] ALU_SLL  = 4'h8;
   localparam logic [3:0] ALU_SRL  = 4'h9;
   localparam logic [3:0] ALU_ROL  = 4'hA;
   localparam logic [3:0] ALU_ROR  = 4'hB;
   localparam logic [3:0] ALU_MUL  = 4'hC;
   localparam logic [3:0] ALU_DIV  = 4'hD;
   localparam logic [3:0] ALU_SNE  = 4'hE;
   localparam logic [3:0] ALU_RSVD = 4'hF;

   // Returns {funct_is_defined, alu_op}; undefined functs fall back to ADD.
   function automatic logic [4:0] funct_to_alu(input logic [5:0] funct);
      case (funct)
         FN_ADD:  return {1'b1, ALU_ADD};
         FN_SUB:  return {1'b1, ALU_SUB};
         FN_MUL:  return {1'b1, ALU_MUL};
         FN_DIV:  return {1'b1, ALU_DIV};
         FN_AND:  return {1'b1, ALU_AND};
         FN_OR:   return {1'b1, ALU_OR};
         FN_XOR:  return {1'b1, ALU_XOR};
         FN_NOR:  return {1'b1, ALU_NOR};
         FN_NAND: return {1'b1, ALU_NAND};
         FN_XNOR: return {1'b1, ALU_XNOR};
         FN_SLL:  return {1'b1, ALU_SLL};
         FN_SRL:  return {1'b1, ALU_SRL};
         FN_ROL:  return {1'b1, ALU_ROL};
         FN_ROR:  return {1'b1, ALU_ROR};
         default: return {1'b0, ALU_ADD};
      endcase
   endfunction

endpackage

// File: rtl/mps16_exec_ctrl_if.sv
// Bundle between the execute stage and its neighbours: fetch/regfile inputs, control and PC outputs.
interface mps16_exec_ctrl_if;
   logic [31:0] instr;
   logic [15:0] rd1;
   logic [15:0] rd2;
   logic [31:0] pc;
   logic        reg_dst;
   logic        alu_src;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        branch;
   logic        jump;
   logic [3:0]  alu_op;
   logic [15:0] alu_out;
   logic        zero;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   // HI/LO are exposed so the multiply/divide side effects are observable.
   logic [15:0] hi;
   logic [15:0] lo;

   modport master (
      output instr, rd1, rd2, pc,
      input  reg_dst, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, jump,
      input  alu_op, alu_out, zero, pc_plus4, next_pc, hi, lo
   );

   modport slave (
      input  instr, rd1, rd2, pc,
      output reg_dst, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, jump,
      output alu_op, alu_out, zero, pc_plus4, next_pc, hi, lo
   );
endinterface

// File: rtl/mps16_alu.sv
// 16-bit unsigned ALU with branch flag; also exposes product high half and remainder for HI/LO.
module mps16_alu
   import mps16_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [3:0]  op,
   output logic [15:0] result,
   output logic [15:0] prod_hi,
   output logic [15:0] rem,
   output logic        zero
);

   logic [31:0] prod;
   logic [15:0] quot;

   assign prod    = 32'(a) * 32'(b);
   assign prod_hi = prod[31:16];
   // Divide by zero yields an all-ones quotient and passes the dividend through as remainder.
   assign quot    = (b == 16'h0000) ? 16'hFFFF : a / b;
   assign rem     = (b == 16'h0000) ? a : a % b;

   always_comb begin
      result = 16'h0000;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_NAND: result = ~(a & b);
         ALU_XNOR: result = ~(a ^ b);
         ALU_SLL:  result = b[4] ? 16'h0000 : a << b[3:0];
         ALU_SRL:  result = b[4] ? 16'h0000 : a >> b[3:0];
         ALU_ROL:  result = {a[14:0], a[15]};
         ALU_ROR:  result = {a[0], a[15:1]};
         ALU_MUL:  result = prod[15:0];
         ALU_DIV:  result = quot;
         default:  result = 16'h0000;
      endcase
   end

   assign zero = (op == ALU_SNE) ? (a != b) : (result == 16'h0000);

endmodule

// File: rtl/mps16_exec_ctrl.sv
// Decode-and-execute core: instruction decode, ALU with HI/LO, and next-PC selection.
module mps16_exec_ctrl
   import mps16_pkg::*;
(
   input logic              clk,
   input logic              reset,
   mps16_exec_ctrl_if.slave bus
);

   logic [5:0]  opcode;
   logic [4:0]  fn_dec;
   logic        d_reg_dst, d_alu_src, d_reg_write, d_mem_read;
   logic        d_mem_write, d_mem_to_reg, d_branch, d_jump;
   logic [3:0]  d_alu_op;
   logic [15:0] alu_b, alu_res, prod_hi, rem;
   logic        alu_zero;
   logic [31:0] pc_plus4, branch_tgt, jump_tgt;
   logic [15:0] hi_q, lo_q;

   assign opcode = bus.instr[31:26];
   assign fn_dec = funct_to_alu(bus.instr[5:0]);

   always_comb begin
      // NOTE: every decode output is defaulted first so no opcode path can infer a latch.
      d_reg_dst    = 1'b0;
      d_alu_src    = 1'b0;
      d_reg_write  = 1'b0;
      d_mem_read   = 1'b0;
      d_mem_write  = 1'b0;
      d_mem_to_reg = 1'b0;
      d_branch     = 1'b0;
      d_jump       = 1'b0;
      d_alu_op     = ALU_ADD;
      case (opcode)
         OP_RTYPE: if (fn_dec[4]) begin
            d_reg_dst   = 1'b1;
            d_alu_op    = fn_dec[3:0];
            d_reg_write = (fn_dec[3:0] != ALU_MUL) && (fn_dec[3:0] != ALU_DIV);
         end
         OP_ADDI: begin
            d_alu_src   = 1'b1;
            d_reg_write = 1'b1;
         end
         OP_LW: begin
            d_alu_src    = 1'b1;
            d_mem_read   = 1'b1;
            d_mem_to_reg = 1'b1;
            d_reg_write  = 1'b1;
         end
         OP_SW: begin
            d_alu_src   = 1'b1;
            d_mem_write = 1'b1;
         end
         OP_BEQ: begin
            d_branch = 1'b1;
            d_alu_op = ALU_SUB;
         end
         OP_BNE: begin
            d_branch = 1'b1;
            d_alu_op = ALU_SNE;
         end
         OP_J:    d_jump = 1'b1;
         default: ;
      endcase
   end

   assign alu_b = d_alu_src ? bus.instr[15:0] : bus.rd2;

   mps16_alu u_alu (
      .a       (bus.rd1),
      .b       (alu_b),
      .op      (d_alu_op),
      .result  (alu_res),
      .prod_hi (prod_hi),
      .rem     (rem),
      .zero    (alu_zero)
   );

   // Offsets are byte offsets taken as-is; the jump target carries no PC bits.
   assign pc_plus4   = bus.pc + 32'd4;
   assign branch_tgt = pc_plus4 + {{16{bus.instr[15]}}, bus.instr[15:0]};
   assign jump_tgt   = {{6{bus.instr[25]}}, bus.instr[25:0]};

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so HI/LO behave as true flops sampled on the edge.
      if (reset) begin
         hi_q <= 16'h0000;
         lo_q <= 16'h0000;
      end else if (d_alu_op == ALU_MUL) begin
         hi_q <= prod_hi;
         lo_q <= alu_res;
      end else if (d_alu_op == ALU_DIV) begin
         hi_q <= rem;
         lo_q <= alu_res;
      end
   end

   assign bus.reg_dst    = d_reg_dst;
   assign bus.alu_src    = d_alu_src;
   assign bus.mem_to_reg = d_mem_to_reg;
   assign bus.reg_write  = d_reg_write & ~reset;
   assign bus.mem_read   = d_mem_read  & ~reset;
   assign bus.mem_write  = d_mem_write & ~reset;
   assign bus.branch     = d_branch    & ~reset;
   assign bus.jump       = d_jump      & ~reset;
   assign bus.alu_op     = d_alu_op;
   assign bus.alu_out    = alu_res;
   assign bus.zero       = alu_zero;
   assign bus.pc_plus4   = pc_plus4;
   assign bus.next_pc    = reset                  ? 32'h0000_0000 :
                           d_jump                 ? jump_tgt      :
                           (d_branch & alu_zero)  ? branch_tgt    : pc_plus4;
   assign bus.hi         = hi_q;
   assign bus.lo         = lo_q;

endmodule

// File: tb/tb_mps16_exec_ctrl.sv
// Self-checking bench for mps16_exec_ctrl: directed scenarios plus randomized traffic against an arithmetic model.
module tb_mps16_exec_ctrl;

   typedef struct packed {
      logic        reg_dst, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, jump;
      logic [3:0]  alu_op;
      logic [15:0] alu_out;
      logic        zero;
      logic [31:0] pc_plus4;
      logic [31:0] next_pc;
   } exp_t;

   localparam logic [5:0]  RT_FN  [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                          6'h28, 6'h2A, 6'h00, 6'h02, 6'h38, 6'h30};
   localparam logic [15:0] RT_OUT [12] = '{16'h003C, 16'h0032, 16'h0005, 16'h0037, 16'h0032, 16'hFFC8,
                                          16'hFFFA, 16'hFFCD, 16'h06E0, 16'h0001, 16'h006E, 16'h801B};
   localparam logic [5:0]  ALL_FN [14] = '{6'h20, 6'h22, 6'h18, 6'h1A, 6'h24, 6'h25, 6'h26,
                                          6'h27, 6'h28, 6'h2A, 6'h00, 6'h02, 6'h38, 6'h30};

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_cur;
   logic [15:0] m_hi = 16'h0000, m_lo = 16'h0000;
   logic [15:0] exp_hi, exp_lo;

   always #5 clk = ~clk;

   mps16_exec_ctrl_if bus ();

   mps16_exec_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] r_ins(input logic [5:0] fn);
      return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [15:0] imm);
      return {op, 5'd1, 5'd2, imm};
   endfunction

   // Reference behaviour from the instruction rules, using plain integer arithmetic.
   function automatic exp_t ref_model(input logic [31:0] ins, input logic [15:0] r1, input logic [15:0] r2,
                                      input logic [31:0] p, input logic rst);
      exp_t   e;
      longint a, b, sh, res, off;
      int     code;
      e = '0;
      code = 0;
      case (int'(ins[31:26]))
         0: begin
            case (int'(ins[5:0]))
               32: code = 0;  34: code = 1;  36: code = 2;  37: code = 3;
               38: code = 4;  39: code = 5;  40: code = 6;  42: code = 7;
               0:  code = 8;  2:  code = 9;  56: code = 10; 48: code = 11;
               24: code = 12; 26: code = 13;
               default: code = -1;
            endcase
            if (code >= 0) begin
               e.reg_dst = 1'b1;
               e.reg_write = (code < 12);
            end else code = 0;
         end
         8:  begin e.alu_src = 1'b1; e.reg_write = 1'b1; end
         35: begin e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
         43: begin e.alu_src = 1'b1; e.mem_write = 1'b1; end
         4:  begin e.branch = 1'b1; code = 1; end
         5:  begin e.branch = 1'b1; code = 14; end
         2:  e.jump = 1'b1;
         default: ;
      endcase
      e.alu_op = 4'(code);
      a  = longint'(r1);
      b  = e.alu_src ? longint'(ins[15:0]) : longint'(r2);
      sh = b % 32;
      case (code)
         0:  res = (a + b) % 65536;
         1:  res = (a - b + 65536) % 65536;
         2:  res = a & b;
         3:  res = a | b;
         4:  res = a ^ b;
         5:  res = 65535 - (a | b);
         6:  res = 65535 - (a & b);
         7:  res = 65535 - (a ^ b);
         8:  res = (sh >= 16) ? 0 : (a * (64'd1 << sh)) % 65536;
         9:  res = (sh >= 16) ? 0 : a / (64'd1 << sh);
         10: res = (a * 2) % 65536 + a / 32768;
         11: res = a / 2 + (a % 2) * 32768;
         12: res = (a * b) % 65536;
         13: res = (b == 0) ? 65535 : a / b;
         default: res = 0;
      endcase
      e.alu_out  = res[15:0];
      e.zero     = (code == 14) ? (a != b) : (res == 0);
      e.pc_plus4 = p + 32'd4;
      off = ins[15] ? longint'(ins[15:0]) - 65536 : longint'(ins[15:0]);
      if (e.jump) begin
         off = ins[25] ? longint'(ins[25:0]) - 67108864 : longint'(ins[25:0]);
         e.next_pc = 32'(off);
      end else if (e.branch && e.zero) e.next_pc = 32'(longint'(p) + 4 + off);
      else e.next_pc = e.pc_plus4;
      if (rst) begin
         e.reg_write = 1'b0; e.mem_read = 1'b0; e.mem_write = 1'b0;
         e.branch = 1'b0; e.jump = 1'b0; e.next_pc = 32'h0;
      end
      return e;
   endfunction

   // Drive one instruction mid-cycle; exp_hi/exp_lo hold what HI/LO should read now, before the next edge.
   task automatic apply(input logic rst, input logic [31:0] ins, input logic [15:0] r1, input logic [15:0] r2,
                        input logic [31:0] p);
      longint a, b;
      @(negedge clk);
      reset = rst; bus.instr = ins; bus.rd1 = r1; bus.rd2 = r2; bus.pc = p;
      #1;
      exp_cur = ref_model(ins, r1, r2, p, rst);
      exp_hi = m_hi;
      exp_lo = m_lo;
      a = longint'(r1);
      b = longint'(r2);
      if (rst) begin
         m_hi = 16'h0; m_lo = 16'h0;
      end else if (exp_cur.alu_op == 4'd12) begin
         m_hi = 16'((a * b) / 65536); m_lo = 16'((a * b) % 65536);
      end else if (exp_cur.alu_op == 4'd13) begin
         m_hi = (b == 0) ? r1 : 16'(a % b);
         m_lo = (b == 0) ? 16'hFFFF : 16'(a / b);
      end
   endtask

   task automatic test_reset();
      apply(1'b1, i_ins(6'h23, 16'h0004), 16'h0010, 16'h0000, 32'd40);
      checks++;
      if ({bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump} !== 5'b0)
         begin failures++; $display("FAIL reset_lw_strobes got %b exp 00000",
            {bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump}); end
      checks++;
      if (bus.next_pc !== 32'h0) begin failures++; $display("FAIL reset_next_pc got %h exp 0", bus.next_pc); end
      apply(1'b1, {6'b000010, 26'h0000074}, 16'h0068, 16'h0068, 32'd104);
      checks++;
      if (bus.jump !== 1'b0 || bus.next_pc !== 32'h0)
         begin failures++; $display("FAIL reset_jump got jump=%b pc=%h exp 0/0", bus.jump, bus.next_pc); end
      checks++;
      if (bus.hi !== 16'h0 || bus.lo !== 16'h0)
         begin failures++; $display("FAIL reset_hilo got %h/%h exp 0000/0000", bus.hi, bus.lo); end
   endtask

   task automatic test_rtype_alu();
      for (int i = 0; i < 12; i++) begin
         apply(1'b0, r_ins(RT_FN[i]), 16'h0037, 16'h0005, 32'd0);
         checks++;
         if (bus.alu_out !== RT_OUT[i])
            begin failures++; $display("FAIL rtype_out[%0d] got %h exp %h", i, bus.alu_out, RT_OUT[i]); end
         checks++;
         if (bus.alu_op !== 4'(i))
            begin failures++; $display("FAIL rtype_op[%0d] got %h exp %h", i, bus.alu_op, 4'(i)); end
         checks++;
         if ({bus.reg_dst, bus.reg_write, bus.alu_src} !== 3'b110)
            begin failures++; $display("FAIL rtype_ctrl[%0d] got %b exp 110", i,
               {bus.reg_dst, bus.reg_write, bus.alu_src}); end
      end
      apply(1'b0, r_ins(6'h00), 16'h0037, 16'h0010, 32'd0);
      checks++;
      if (bus.alu_out !== 16'h0000) begin failures++; $display("FAIL sll_16 got %h exp 0000", bus.alu_out); end
      apply(1'b0, r_ins(6'h00), 16'h0037, 16'h0024, 32'd0);
      checks++;
      if (bus.alu_out !== 16'h0370) begin failures++; $display("FAIL sll_b4_0 got %h exp 0370", bus.alu_out); end
      apply(1'b0, r_ins(6'h02), 16'h8000, 16'h000F, 32'd0);
      checks++;
      if (bus.alu_out !== 16'h0001) begin failures++; $display("FAIL srl_15 got %h exp 0001", bus.alu_out); end
   endtask

   task automatic test_mult_div();
      apply(1'b0, r_ins(6'h18), 16'h0037, 16'h0005, 32'd0);
      checks++;
      if (bus.alu_out !== 16'h0113 || bus.reg_write !== 1'b0)
         begin failures++; $display("FAIL mul got %h rw=%b exp 0113 rw=0", bus.alu_out, bus.reg_write); end
      apply(1'b0, r_ins(6'h1A), 16'h0037, 16'h0005, 32'd0);
      checks++;
      if (bus.alu_out !== 16'h000B || bus.reg_write !== 1'b0)
         begin failures++; $display("FAIL div got %h rw=%b exp 000B rw=0", bus.alu_out, bus.reg_write); end
      checks++;
      if (bus.hi !== 16'h0000 || bus.lo !== 16'h0113)
         begin failures++; $display("FAIL hilo_mul got %h/%h exp 0000/0113", bus.hi, bus.lo); end
      apply(1'b0, r_ins(6'h1A), 16'h0037, 16'h0000, 32'd0);
      checks++;
      if (bus.hi !== 16'h0000 || bus.lo !== 16'h000B)
         begin failures++; $display("FAIL hilo_div got %h/%h exp 0000/000B", bus.hi, bus.lo); end
      checks++;
      if (bus.alu_out !== 16'hFFFF) begin failures++; $display("FAIL div0 got %h exp FFFF", bus.alu_out); end
      apply(1'b0, r_ins(6'h18), 16'hFFFF, 16'hFFFF, 32'd0);
      checks++;
      if (bus.hi !== 16'h0037 || bus.lo !== 16'hFFFF)
         begin failures++; $display("FAIL hilo_div0 got %h/%h exp 0037/FFFF", bus.hi, bus.lo); end
      checks++;
      if (bus.alu_out !== 16'h0001) begin failures++; $display("FAIL mul_max got %h exp 0001", bus.alu_out); end
      apply(1'b0, r_ins(6'h20), 16'h0001, 16'h0001, 32'd0);
      checks++;
      if (bus.hi !== 16'hFFFE || bus.lo !== 16'h0001)
         begin failures++; $display("FAIL hilo_mulmax got %h/%h exp FFFE/0001", bus.hi, bus.lo); end
      checks++;
      if (bus.hi !== 16'hFFFE || bus.lo !== 16'h0001)
         begin failures++; $display("FAIL hilo_hold_pre got %h/%h exp FFFE/0001", bus.hi, bus.lo); end
      apply(1'b1, r_ins(6'h18), 16'h0037, 16'h0005, 32'd0);
      checks++;
      if (bus.hi !== 16'hFFFE || bus.lo !== 16'h0001)
         begin failures++; $display("FAIL hilo_hold got %h/%h exp FFFE/0001", bus.hi, bus.lo); end
      apply(1'b0, r_ins(6'h20), 16'h0001, 16'h0001, 32'd0);
      checks++;
      if (bus.hi !== 16'h0000 || bus.lo !== 16'h0000)
         begin failures++; $display("FAIL hilo_reset got %h/%h exp 0000/0000", bus.hi, bus.lo); end
   endtask

   task automatic test_itype();
      apply(1'b0, i_ins(6'h08, 16'h0005), 16'h004E, 16'h1234, 32'd0);
      checks++;
      if (bus.alu_out !== 16'h0053 || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0 || bus.alu_src !== 1'b1)
         begin failures++; $display("FAIL addi got %h rw=%b rd=%b src=%b exp 0053 1 0 1",
            bus.alu_out, bus.reg_write, bus.reg_dst, bus.alu_src); end
      apply(1'b0, i_ins(6'h2B, 16'h0004), 16'h0100, 16'h00AA, 32'd0);
      checks++;
      if ({bus.mem_write, bus.mem_read, bus.reg_write, bus.mem_to_reg} !== 4'b1000 || bus.alu_out !== 16'h0104)
         begin failures++; $display("FAIL sw got %b %h exp 1000 0104",
            {bus.mem_write, bus.mem_read, bus.reg_write, bus.mem_to_reg}, bus.alu_out); end
      apply(1'b0, i_ins(6'h23, 16'h0004), 16'h0100, 16'h00AA, 32'd0);
      checks++;
      if ({bus.mem_write, bus.mem_read, bus.reg_write, bus.mem_to_reg} !== 4'b0111 || bus.alu_out !== 16'h0104)
         begin failures++; $display("FAIL lw got %b %h exp 0111 0104",
            {bus.mem_write, bus.mem_read, bus.reg_write, bus.mem_to_reg}, bus.alu_out); end
      apply(1'b0, i_ins(6'h3F, 16'hFFFF), 16'h0001, 16'h0002, 32'd0);
      checks++;
      if ({bus.reg_dst, bus.alu_src, bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg,
           bus.branch, bus.jump} !== 8'h00 || bus.alu_op !== 4'h0)
         begin failures++; $display("FAIL bad_opcode got op=%h exp 0 with strobes 0", bus.alu_op); end
      apply(1'b0, r_ins(6'h01), 16'h0001, 16'h0002, 32'd0);
      checks++;
      if ({bus.reg_dst, bus.reg_write} !== 2'b00 || bus.alu_op !== 4'h0)
         begin failures++; $display("FAIL bad_funct got rd=%b rw=%b op=%h exp 0 0 0",
            bus.reg_dst, bus.reg_write, bus.alu_op); end
   endtask

   task automatic test_branch_jump();
      apply(1'b0, i_ins(6'h04, 16'h0008), 16'h0068, 16'h0068, 32'd76);
      checks++;
      if (bus.next_pc !== 32'd88 || bus.zero !== 1'b1 || bus.branch !== 1'b1)
         begin failures++; $display("FAIL beq_taken got %0d z=%b exp 88 z=1", bus.next_pc, bus.zero); end
      apply(1'b0, i_ins(6'h05, 16'h0004), 16'h0033, 16'h0068, 32'd92);
      checks++;
      if (bus.next_pc !== 32'd100 || bus.alu_out !== 16'h0)
         begin failures++; $display("FAIL bne_taken got %0d out=%h exp 100 out=0", bus.next_pc, bus.alu_out); end
      apply(1'b0, i_ins(6'h04, 16'h0008), 16'h0033, 16'h0068, 32'd76);
      checks++;
      if (bus.next_pc !== 32'd80) begin failures++; $display("FAIL beq_not got %0d exp 80", bus.next_pc); end
      apply(1'b0, i_ins(6'h04, 16'hFFF8), 16'h0068, 16'h0068, 32'd76);
      checks++;
      if (bus.next_pc !== 32'd72) begin failures++; $display("FAIL beq_back got %0d exp 72", bus.next_pc); end
      apply(1'b0, i_ins(6'h08, 16'h0001), 16'h0000, 16'h0000, 32'hFFFF_FFFC);
      checks++;
      if (bus.pc_plus4 !== 32'h0 || bus.next_pc !== 32'h0)
         begin failures++; $display("FAIL pc_wrap got %h/%h exp 0/0", bus.pc_plus4, bus.next_pc); end
      apply(1'b0, {6'b000010, 26'h0000074}, 16'h0000, 16'h0000, 32'd104);
      checks++;
      if (bus.next_pc !== 32'd116 || bus.jump !== 1'b1)
         begin failures++; $display("FAIL j got %0d exp 116", bus.next_pc); end
      apply(1'b0, {6'b000010, 26'h2000010}, 16'h0000, 16'h0000, 32'd104);
      checks++;
      if (bus.next_pc !== 32'hFE00_0010) begin failures++; $display("FAIL j_neg got %h exp FE000010", bus.next_pc); end
   endtask

   task automatic test_random();
      logic [31:0] r, ins, p;
      logic [15:0] r1, r2;
      logic [5:0]  opc, fn;
      logic        rst;
      logic [7:0]  got_c, exp_c;
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: opc = 6'h00;
            3:       opc = 6'h08;
            4:       opc = 6'h23;
            5:       opc = 6'h2B;
            6:       opc = 6'h04;
            7:       opc = 6'h05;
            8:       opc = 6'h02;
            default: opc = 6'($urandom_range(0, 63));
         endcase
         fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : ALL_FN[$urandom_range(0, 13)];
         r = $urandom();
         ins = {opc, r[25:6], fn};
         r1 = 16'($urandom());
         case ($urandom_range(0, 5))
            0:       r2 = r1;
            1:       r2 = 16'h0000;
            2:       r2 = 16'($urandom_range(0, 31));
            default: r2 = 16'($urandom());
         endcase
         p = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom();
         rst = ($urandom_range(0, 19) == 0);
         apply(rst, ins, r1, r2, p);
         got_c = {bus.reg_dst, bus.alu_src, bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                  bus.branch, bus.jump};
         exp_c = {exp_cur.reg_dst, exp_cur.alu_src, exp_cur.reg_write, exp_cur.mem_read, exp_cur.mem_write,
                  exp_cur.mem_to_reg, exp_cur.branch, exp_cur.jump};
         checks++;
         if (got_c !== exp_c)
            begin failures++; $display("FAIL rnd_ctrl ins=%h got %b exp %b", ins, got_c, exp_c); end
         checks++;
         if (bus.alu_op !== exp_cur.alu_op)
            begin failures++; $display("FAIL rnd_op ins=%h got %h exp %h", ins, bus.alu_op, exp_cur.alu_op); end
         checks++;
         if (bus.alu_out !== exp_cur.alu_out || bus.zero !== exp_cur.zero)
            begin failures++; $display("FAIL rnd_alu ins=%h a=%h b=%h got %h z=%b exp %h z=%b", ins, r1, r2,
               bus.alu_out, bus.zero, exp_cur.alu_out, exp_cur.zero); end
         checks++;
         if (bus.pc_plus4 !== exp_cur.pc_plus4 || bus.next_pc !== exp_cur.next_pc)
            begin failures++; $display("FAIL rnd_pc ins=%h pc=%h got %h/%h exp %h/%h", ins, p,
               bus.pc_plus4, bus.next_pc, exp_cur.pc_plus4, exp_cur.next_pc); end
         checks++;
         if (bus.hi !== exp_hi || bus.lo !== exp_lo)
            begin failures++; $display("FAIL rnd_hilo got %h/%h exp %h/%h", bus.hi, bus.lo, exp_hi, exp_lo); end
      end
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_rtype_alu();
      test_mult_div();
      test_itype();
      test_branch_jump();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
